// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the pc, issues word reads to a synchronous imem,
// and buffers the returned words in a small prefetch FIFO in front of decode.
module ifetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc_out,
  output logic              cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic              inflight;
  logic              kill;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       dmem [DEPTH];
  logic [ADDR_W-1:0] amem [DEPTH];

  logic              pop;
  logic              push;
  logic [CW:0]       occ;

  // Occupancy after this cycle's pop, counting the word still in flight.
  always_comb begin
    cnt       = ~rst & (count != '0);
    pop       = cnt & ~stall & ~redirect;
    push      = ~rst & ~redirect & inflight & ~kill;
    occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    imem_req  = ~rst & ~redirect & (occ < (CW+1)'(DEPTH));
    imem_addr = rst ? RESET_PC : pc;
    inst      = '0;
    pc_out    = '0;
    if (cnt) begin
      inst   = dmem[rd_ptr];
      pc_out = amem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      kill     <= inflight;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        dmem[wr_ptr] <= imem_rdata;
        amem[wr_ptr] <= req_addr;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (imem_req) begin
        pc       <= pc + ADDR_W'(4);
        req_addr <= pc;
      end
      inflight <= imem_req;
      kill     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit with a one-cycle-latency imem model
// that returns addr>>2 as data.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        cnt;

  int total = 0;
  int bad   = 0;

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst(inst), .pc_out(pc_out), .cnt(cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_req) imem_rdata <= imem_addr >> 2;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ecnt;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic ec, input logic [31:0] ei, input logic [31:0] ep,
                     input logic eq, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc;
    v.ecnt = ec; v.einst = ei; v.epc = ep; v.ereq = eq; v.eaddr = ea;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //   rst stall redir rpc          cnt inst         pc_out       req addr
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h4);
    add(0, 0, 0, 32'h0,        1, 32'h0,        32'h0,        1, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h1,        32'h4,        1, 32'hC);
    add(0, 1, 0, 32'h0,        1, 32'h2,        32'h8,        0, 32'h10);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 32'h0,      1, 32'h2,        32'h8,        0, 32'h10);
    add(0, 0, 0, 32'h0,        1, 32'h2,        32'h8,        1, 32'h10);
    add(0, 0, 0, 32'h0,        1, 32'h3,        32'hC,        1, 32'h14);
    add(0, 0, 0, 32'h0,        1, 32'h4,        32'h10,       1, 32'h18);
    add(0, 0, 1, 32'h100,      1, 32'h5,        32'h14,       0, 32'h1C);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h100);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h104);
    add(0, 0, 0, 32'h0,        1, 32'h40,       32'h100,      1, 32'h108);
    add(0, 1, 1, 32'h103,      1, 32'h41,       32'h104,      0, 32'h10C);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h100);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h104);
    add(0, 0, 0, 32'h0,        1, 32'h40,       32'h100,      1, 32'h108);
    add(0, 1, 0, 32'h0,        1, 32'h41,       32'h104,      0, 32'h10C);
    add(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h4);
    add(0, 0, 0, 32'h0,        1, 32'h0,        32'h0,        1, 32'h8);
    add(0, 0, 1, 32'hFFFFFFFC, 1, 32'h1,        32'h4,        0, 32'hC);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'hFFFFFFFC);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0);
    add(0, 0, 0, 32'h0,        1, 32'h3FFFFFFF, 32'hFFFFFFFC, 1, 32'h4);
    add(0, 0, 0, 32'h0,        1, 32'h0,        32'h0,        1, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h1,        32'h4,        1, 32'hC);
    add(1, 0, 1, 32'h200,      0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0);
    add(0, 0, 1, 32'h300,      0, 32'h0,        32'h0,        0, 32'h4);
    add(0, 0, 1, 32'h400,      0, 32'h0,        32'h0,        0, 32'h300);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h400);
    add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h404);
    add(0, 0, 0, 32'h0,        1, 32'h100,      32'h400,      1, 32'h408);

    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; stall = vq[i].stall;
      redirect = vq[i].redir; redirect_pc = vq[i].rpc;
      #1;
      chk("cnt",       i, {31'd0, cnt},      {31'd0, vq[i].ecnt});
      chk("inst",      i, inst,              vq[i].einst);
      chk("pc_out",    i, pc_out,            vq[i].epc);
      chk("imem_req",  i, {31'd0, imem_req}, {31'd0, vq[i].ereq});
      chk("imem_addr", i, imem_addr,         vq[i].eaddr);
    end

    // Redirect latency measured with a bounded wait, then two in-order words.
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    n = 0;
    do begin
      @(negedge clk);
      redirect = 1'b0;
      n++;
      #1;
    end while (!cnt && n < 10);
    chk("redir_latency", 0, n, 3);
    chk("redir_pc",      0, pc_out, 32'h80);
    chk("redir_inst",    0, inst,   32'h20);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #1;
      chk("stream_cnt",  k, {31'd0, cnt}, 32'd1);
      chk("stream_pc",   k, pc_out, 32'h80 + 32'(k * 4));
      chk("stream_inst", k, inst,   32'h20 + 32'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
